// File: rtl/otp_key_server_mc.sv
// Multi-channel OTP key/nonce server: round-robin grants over a 4-phase req/ack
// handshake, each grant stepping per-stream Fibonacci LFSRs before delivery.
module otp_key_server_mc #(
  parameter int unsigned         NumCh      = 2,
  parameter int unsigned         KeyW       = 128,
  parameter int unsigned         NonceW     = 64,
  parameter logic [KeyW-1:0]     KeySeed    = 128'h4235_0b2f_9c1e_6a58_d07b_3c94_e1a6_163a,
  parameter logic [NonceW-1:0]   NonceSeed  = 64'h7603_55d3_4470_63d1,
  parameter logic [KeyW-1:0]     KeyTaps    = 128'hE100_0000_0000_0000_0000_0000_0000_0000,
  parameter logic [NonceW-1:0]   NonceTaps  = 64'hD800_0000_0000_0000,
  parameter int unsigned         RspLatency = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NumCh-1:0]  req_i,
  input  logic              lock_i,
  output logic [NumCh-1:0]  ack_o,
  output logic [KeyW-1:0]   key_o,
  output logic [NonceW-1:0] nonce_o,
  output logic              seed_valid_o,
  output logic              busy_o
);

  if (NumCh < 1) begin : g_bad_numch
    $fatal(1, "NumCh must be >= 1");
  end
  if (RspLatency < 1) begin : g_bad_latency
    $fatal(1, "RspLatency must be >= 1");
  end
  if (KeyTaps == '0 || NonceTaps == '0) begin : g_bad_taps
    $fatal(1, "LFSR tap masks must be non-zero");
  end
  if (KeyW < 2 || NonceW < 2) begin : g_bad_width
    $fatal(1, "KeyW and NonceW must be >= 2");
  end

  localparam int unsigned IdxW = (NumCh > 1) ? $clog2(NumCh) : 1;
  localparam int unsigned CntW = (RspLatency > 1) ? $clog2(RspLatency) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [CntW-1:0]     cnt_reg, cnt_next;
  logic [IdxW-1:0]     idx_reg, idx_next;
  logic [IdxW-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [NumCh-1:0]    armed_reg, armed_next;
  logic [NumCh-1:0]    eligible;
  logic [NumCh-1:0]    ack_next;
  logic [KeyW-1:0]     key_lfsr_reg, key_lfsr_next;
  logic [NonceW-1:0]   nonce_lfsr_reg, nonce_lfsr_next;
  logic [IdxW-1:0]     grant_idx;
  logic                any_elig;
  logic                step_en;
  logic                ack_fire;

  // One Fibonacci step; an all-zero result would lock the stream, so reload the seed.
  function automatic logic [KeyW-1:0] key_step(input logic [KeyW-1:0] cur);
    logic [KeyW-1:0] nxt;
    nxt = {cur[KeyW-2:0], ^(cur & KeyTaps)};
    return (nxt == '0) ? KeySeed : nxt;
  endfunction

  function automatic logic [NonceW-1:0] nonce_step(input logic [NonceW-1:0] cur);
    logic [NonceW-1:0] nxt;
    nxt = {cur[NonceW-2:0], ^(cur & NonceTaps)};
    return (nxt == '0) ? NonceSeed : nxt;
  endfunction

  for (genvar gi = 0; gi < NumCh; gi++) begin : g_ch
    assign eligible[gi]   = req_i[gi] & armed_reg[gi];
    assign ack_next[gi]   = ack_fire && (idx_reg == IdxW'(gi));
    // Clearing on ack wins; re-arming needs the request to have dropped.
    assign armed_next[gi] = ack_next[gi] ? 1'b0 :
                            (!req_i[gi] ? 1'b1 : armed_reg[gi]);
  end

  always_comb begin
    int unsigned c;
    grant_idx = '0;
    any_elig  = 1'b0;
    c         = 0;
    for (int unsigned off = 0; off < NumCh; off++) begin
      c = 32'(rr_ptr_reg) + off;
      if (c >= NumCh) c = c - NumCh;
      if (!any_elig && eligible[IdxW'(c)]) begin
        any_elig  = 1'b1;
        grant_idx = IdxW'(c);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    step_en    = 1'b0;
    ack_fire   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (any_elig && !lock_i) begin
          state_next = ST_GEN;
          cnt_next   = '0;
          idx_next   = grant_idx;
        end
      end
      ST_GEN: begin
        step_en = 1'b1;
        if (cnt_reg == CntW'(RspLatency - 1)) begin
          state_next = ST_ACK;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_ACK: begin
        ack_fire   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign key_lfsr_next   = step_en ? key_step(key_lfsr_reg) : key_lfsr_reg;
  assign nonce_lfsr_next = step_en ? nonce_step(nonce_lfsr_reg) : nonce_lfsr_reg;
  assign rr_ptr_next     = !ack_fire ? rr_ptr_reg :
                           ((idx_reg == IdxW'(NumCh - 1)) ? '0 : idx_reg + 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      rr_ptr_reg     <= '0;
      armed_reg      <= '1;
      key_lfsr_reg   <= KeySeed;
      nonce_lfsr_reg <= NonceSeed;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      rr_ptr_reg     <= rr_ptr_next;
      armed_reg      <= armed_next;
      key_lfsr_reg   <= key_lfsr_next;
      nonce_lfsr_reg <= nonce_lfsr_next;
    end
  end

  // Output registers: material is captured on the ack and held until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_o        <= '0;
      key_o        <= '0;
      nonce_o      <= '0;
      busy_o       <= 1'b0;
      seed_valid_o <= 1'b1;
    end else begin
      ack_o        <= ack_next;
      busy_o       <= (state_next != ST_IDLE);
      seed_valid_o <= ~lock_i;
      if (ack_fire) begin
        key_o   <= key_lfsr_reg;
        nonce_o <= nonce_lfsr_reg;
      end
    end
  end

endmodule

// File: tb/tb_otp_key_server_mc.sv
// Self-checking bench for otp_key_server_mc: directed steps plus randomized
// request masks, checked against a transaction-level model of grants and LFSRs.
module tb_otp_key_server_mc;

  localparam int R  = 2;
  localparam int RG = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, ack;
  logic       lock, sv, busy;
  logic [7:0] key, nonce;

  logic [1:0] req_g, ack_g;
  logic       lock_g, sv_g, busy_g;
  logic [7:0] key_g, nonce_g;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] key_m, nonce_m;
  int         rr_m;

  always #5 clk = ~clk;

  otp_key_server_mc #(
    .NumCh(2), .KeyW(8), .NonceW(8),
    .KeySeed(8'h01), .NonceSeed(8'h80),
    .KeyTaps(8'hB8), .NonceTaps(8'hB8),
    .RspLatency(R)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req), .lock_i(lock),
    .ack_o(ack), .key_o(key), .nonce_o(nonce),
    .seed_valid_o(sv), .busy_o(busy)
  );

  // Second instance whose taps drive the streams into (or away from) the all-zero state.
  otp_key_server_mc #(
    .NumCh(2), .KeyW(8), .NonceW(8),
    .KeySeed(8'h80), .NonceSeed(8'h80),
    .KeyTaps(8'h80), .NonceTaps(8'h01),
    .RspLatency(RG)
  ) dut_guard (
    .clk(clk), .rst(rst), .req_i(req_g), .lock_i(lock_g),
    .ack_o(ack_g), .key_o(key_g), .nonce_o(nonce_g),
    .seed_valid_o(sv_g), .busy_o(busy_g)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] step8(input logic [7:0] cur, input logic [7:0] taps,
                                       input logic [7:0] seed);
    logic [7:0] n;
    n = (cur << 1) | {7'd0, ^(cur & taps)};
    return (n == 8'h00) ? seed : n;
  endfunction

  // First requesting channel at or after the round-robin pointer.
  function automatic int pick(input logic [1:0] mask, input int rr);
    for (int off = 0; off < 2; off++) begin
      if (mask[(rr + off) % 2]) return (rr + off) % 2;
    end
    return -1;
  endfunction

  task automatic wait_ack(input int sel, input int budget, output int lat, output logic [1:0] a);
    lat = -1;
    a   = 2'b00;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      a = (sel == 0) ? ack : ack_g;
      if (a != 2'b00) begin
        lat = i;
        break;
      end
    end
  endtask

  // exp_lat counts falling edges from the call: 4 after a fresh request,
  // 3 when following a previous serve (which already consumed one edge).
  task automatic serve(input string tag, input int exp_ch, input int exp_lat);
    int         lat;
    logic [1:0] a;
    wait_ack(0, 12, lat, a);
    for (int s = 0; s < R; s++) begin
      key_m   = step8(key_m, 8'hB8, 8'h01);
      nonce_m = step8(nonce_m, 8'hB8, 8'h80);
    end
    rr_m = (exp_ch + 1) % 2;
    $display("txn %s: ch=%0d lat=%0d ack=%b key=%h nonce=%h", tag, exp_ch, lat, a, key, nonce);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_ack"}, 32'(a), 32'(2'b01 << exp_ch));
    chk({tag, "_key"}, 32'(key), 32'(key_m));
    chk({tag, "_nonce"}, 32'(nonce), 32'(nonce_m));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(ack), 32'd0);
  endtask

  initial begin : main
    int         lat;
    logic [1:0] a, mask, rem;
    int         ch;
    bit         first;

    rst = 1'b1; req = 2'b00; lock = 1'b0; req_g = 2'b00; lock_g = 1'b0;
    key_m = 8'h01; nonce_m = 8'h80; rr_m = 0;
    #3;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_key", 32'(key), 32'd0);
    chk("rst_nonce", 32'(nonce), 32'd0);
    chk("rst_sv", 32'(sv), 32'd1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Single request, held afterwards: one ack only.
    @(negedge clk);
    req = 2'b01;
    serve("single", 0, 4);
    chk("single_key04", 32'(key), 32'h04);
    chk("single_nonce02", 32'(nonce), 32'h02);
    wait_ack(0, 8, lat, a);
    chk("held_no_reserve", 32'(a), 32'd0);
    chk("held_busy", 32'(busy), 32'd0);
    req = 2'b00;

    // Asynchronous reset in the middle of a grant.
    @(negedge clk);
    req = 2'b10;
    @(negedge clk);
    chk("midgen_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ack", 32'(ack), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_key", 32'(key), 32'd0);
    chk("arst_nonce", 32'(nonce), 32'd0);
    chk("arst_sv", 32'(sv), 32'd1);
    @(negedge clk);
    rst = 1'b0; req = 2'b00;
    key_m = 8'h01; nonce_m = 8'h80; rr_m = 0;

    // Both held: served in rr order with distinct material.
    @(negedge clk);
    req = 2'b11;
    serve("both0", 0, 4);
    chk("both0_key04", 32'(key), 32'h04);
    serve("both1", 1, 3);
    chk("both1_key11", 32'(key), 32'h11);
    req = 2'b10;
    @(negedge clk);
    req = 2'b11;
    serve("rearm0", 0, 4);
    req = 2'b00;

    // Lock before the request.
    @(negedge clk);
    lock = 1'b1; req = 2'b01;
    @(negedge clk);
    chk("lock_sv", 32'(sv), 32'd0);
    wait_ack(0, 8, lat, a);
    chk("lock_no_ack", 32'(a), 32'd0);
    chk("lock_busy", 32'(busy), 32'd0);
    lock = 1'b0;
    serve("unlock", 0, 4);
    chk("unlock_sv", 32'(sv), 32'd1);
    req = 2'b00;

    // Lock raised mid-grant: the grant completes, later requests are refused.
    @(negedge clk);
    req = 2'b10;
    @(negedge clk);
    lock = 1'b1;
    serve("lockgen", 1, 3);
    req = 2'b00;
    @(negedge clk);
    req = 2'b01;
    wait_ack(0, 8, lat, a);
    chk("lockgen_blocked", 32'(a), 32'd0);
    lock = 1'b0;
    serve("lockgen_release", 0, 4);
    req = 2'b00;

    // Randomized request masks.
    for (int r = 0; r < 12; r++) begin
      @(negedge clk);
      mask  = 2'($urandom_range(1, 3));
      req   = mask;
      rem   = mask;
      first = 1'b1;
      while (rem != 2'b00) begin
        ch = pick(rem, rr_m);
        serve("rnd", ch, first ? 4 : 3);
        rem[ch] = 1'b0;
        first   = 1'b0;
      end
      wait_ack(0, 3, lat, a);
      chk("rnd_no_extra", 32'(a), 32'd0);
      req = 2'b00;
    end

    // Lock-up guard: key 80 -> 01, nonce 80 -> 00 reloads to 80.
    @(negedge clk);
    req_g = 2'b01;
    wait_ack(1, 12, lat, a);
    $display("txn guard1: lat=%0d ack=%b key=%h nonce=%h", lat, a, key_g, nonce_g);
    chk("guard1_lat", 32'(lat), 32'd3);
    chk("guard1_ack", 32'(a), 32'd1);
    chk("guard1_key", 32'(key_g), 32'(step8(8'h80, 8'h80, 8'h80)));
    chk("guard1_key01", 32'(key_g), 32'h01);
    chk("guard1_nonce80", 32'(nonce_g), 32'h80);
    req_g = 2'b00;
    @(negedge clk);
    req_g = 2'b10;
    wait_ack(1, 12, lat, a);
    $display("txn guard2: lat=%0d ack=%b key=%h nonce=%h", lat, a, key_g, nonce_g);
    chk("guard2_ack", 32'(a), 32'd2);
    chk("guard2_key02", 32'(key_g), 32'h02);
    chk("guard2_nonce80", 32'(nonce_g), 32'h80);
    req_g = 2'b00;
    @(negedge clk);
    chk("guard_busy", 32'(busy_g), 32'd0);
    chk("guard_sv", 32'(sv_g), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
